ofs_fim_axis_pkt_len_guard: RTL and testbench

- Single-clock AXI-S stage that sits directly downstream of the clock-crossing FIFO on the receive path (read-clock side).
- Enforces a maximum packet length in beats. An oversize packet is truncated: its beat number MAX_BEATS is forwarded with tlast forced high, and the rest of that packet is silently consumed.
- The output is registered through a 2-entry skid buffer, so no combinational path exists from axis_m_tready to axis_s_tready.
- Exposes truncation and dropped-beat statistics.

---
 rtl/ofs_fim_axis_pkt_len_guard_if.sv | 24 ++
 rtl/ofs_fim_axis_pkt_len_guard.sv | 142 ++++++++++++++
 tb/tb_ofs_fim_axis_pkt_len_guard.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_axis_pkt_len_guard_if.sv
// AXI-S beat bundle used on both sides of the packet length guard.
// trunc only carries meaning on the outbound side, so the slave modport leaves it out.
interface ofs_fim_axis_pkt_len_guard_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser_vendor;
  logic                     tlast;
  logic                     trunc;

  modport master (
    output tvalid, tdata, tkeep, tuser_vendor, tlast, trunc,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tuser_vendor, tlast,
    output tready
  );
endinterface

// File: rtl/ofs_fim_axis_pkt_len_guard.sv
// Receive-path packet length guard, placed after the clock-crossing FIFO.
// Packets longer than MAX_BEATS are cut: beat MAX_BEATS goes out with tlast
// forced and trunc set, and the tail of that packet is swallowed.
// Output is a 2-entry skid (main + skid register), so axis_s.tready is a
// pure register output with no path from axis_m.tready.
// TDATA_WIDTH must be a multiple of 8; MAX_BEATS must be at least 1.
module ofs_fim_axis_pkt_len_guard #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int MAX_BEATS   = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ofs_fim_axis_pkt_len_guard_if.slave  axis_s,
  ofs_fim_axis_pkt_len_guard_if.master axis_m,
  output logic [CNT_WIDTH-1:0] trunc_count,
  output logic [CNT_WIDTH-1:0] drop_beat_count
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int IDX_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BEATS - 1);

  typedef enum logic {PASS, DROP} state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]      keep;
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
    logic                   trunc;
  } beat_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             trunc_now;
  logic             s_accept, fwd, drop_beat;
  logic             main_vld, skid_vld, main_free;
  beat_t            main_q, skid_q, in_beat;

  // In DROP the input is always drained; in PASS we only stall when the skid is occupied.
  assign axis_s.tready = (state_q == DROP) | ~skid_vld;
  assign s_accept      = axis_s.tvalid & axis_s.tready;
  assign fwd           = s_accept & (state_q == PASS);
  assign drop_beat     = s_accept & (state_q == DROP);

  assign in_beat.data  = axis_s.tdata;
  assign in_beat.keep  = axis_s.tkeep;
  assign in_beat.user  = axis_s.tuser_vendor;
  assign in_beat.last  = axis_s.tlast | trunc_now;
  assign in_beat.trunc = trunc_now;

  // Next state, beat index and truncation decision for the beat being accepted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    trunc_now = 1'b0;
    if (s_accept) begin
      case (state_q)
        PASS: begin
          if (axis_s.tlast) begin
            idx_d = '0;
          end else if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            trunc_now = 1'b1;
            state_d   = DROP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DROP: begin
          if (axis_s.tlast) state_d = PASS;
        end
        default: state_d = PASS;
      endcase
    end
  end

  // FSM and beat index registers; reset makes the next accepted beat a start of packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Saturating statistics: one truncation or one dropped beat per cycle at most.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trunc_count     <= '0;
      drop_beat_count <= '0;
    end else begin
      if (trunc_now && !(&trunc_count))
        trunc_count <= trunc_count + CNT_WIDTH'(1);
      if (drop_beat && !(&drop_beat_count))
        drop_beat_count <= drop_beat_count + CNT_WIDTH'(1);
    end
  end

  // Main register can take a beat when it is empty or being drained this cycle.
  assign main_free = ~main_vld | axis_m.tready;

  // Main/skid occupancy. A held skid entry always has priority over new input,
  // and new input cannot arrive while the skid is full (tready is low in PASS).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (fwd) begin
        main_q   <= in_beat;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (fwd) begin
      skid_vld <= 1'b1;
    end
  end

  // Skid payload only needs capturing when a beat arrives behind a stalled main entry.
  always_ff @(posedge clk) begin
    if (!main_free && fwd) skid_q <= in_beat;
  end

  assign axis_m.tvalid       = main_vld;
  assign axis_m.tdata        = main_q.data;
  assign axis_m.tkeep        = main_q.keep;
  assign axis_m.tuser_vendor = main_q.user;
  assign axis_m.tlast        = main_q.last;
  assign axis_m.trunc        = main_q.trunc;

endmodule

// File: tb/tb_ofs_fim_axis_pkt_len_guard.sv
// Directed bench for the packet length guard. Four instances cover the
// MAX_BEATS / CNT_WIDTH variants; all see the same stimulus and `sel` picks
// the one being checked. Every test begins with a reset.
module tb_ofs_fim_axis_pkt_len_guard;
  localparam int DW = 32;
  localparam int UW = 10;
  localparam int KW = DW / 8;
  localparam int PW = DW + KW + UW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic [KW-1:0] s_tkeep  = '0;
  logic [UW-1:0] s_tuser  = '0;
  logic          s_tlast  = 1'b0;
  logic          m_tready = 1'b0;
  int            sel      = 0;

  logic          s_rdy_a [4];
  logic          m_vld_a [4];
  logic [PW-1:0] m_pay_a [4];
  logic [31:0]   tc_a    [4];
  logic [31:0]   dc_a    [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gd
      localparam int MB = (g == 0) ? 64 : (g == 1) ? 4 : (g == 2) ? 2 : 1;
      localparam int CW = (g == 3) ? 2 : 32;
      ofs_fim_axis_pkt_len_guard_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) si ();
      ofs_fim_axis_pkt_len_guard_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) so ();
      logic [CW-1:0] tc, dc;
      assign si.tvalid       = s_tvalid;
      assign si.tdata        = s_tdata;
      assign si.tkeep        = s_tkeep;
      assign si.tuser_vendor = s_tuser;
      assign si.tlast        = s_tlast;
      assign si.trunc        = 1'b0;
      assign so.tready       = m_tready;
      ofs_fim_axis_pkt_len_guard #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .MAX_BEATS(MB), .CNT_WIDTH(CW)
      ) dut (
        .clk(clk), .rst_n(rst_n), .axis_s(si), .axis_m(so),
        .trunc_count(tc), .drop_beat_count(dc)
      );
      assign s_rdy_a[g] = si.tready;
      assign m_vld_a[g] = so.tvalid;
      assign m_pay_a[g] = {so.tdata, so.tkeep, so.tuser_vendor, so.tlast, so.trunc};
      assign tc_a[g]    = 32'(tc);
      assign dc_a[g]    = 32'(dc);
    end
  endgenerate

  logic          s_rdy, m_vld;
  logic [PW-1:0] m_pay;
  logic [31:0]   tc, dc;
  always_comb begin
    s_rdy = s_rdy_a[sel];
    m_vld = m_vld_a[sel];
    m_pay = m_pay_a[sel];
    tc    = tc_a[sel];
    dc    = dc_a[sel];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [PW-1:0] sb_q [$];
  int            out_cyc [$];

  // reference model state
  int mb, mdl_idx;
  bit mdl_drop;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pop on transfer, stability check while stalled.
  logic [PW-1:0] held;
  logic          hold_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", PW'(m_vld), PW'(1));
        check("hold_stable", m_pay, held);
      end
      hold_pend <= 1'b0;
      if (m_vld && m_tready) begin
        if (sb_q.size() == 0) check("sb_extra_beat", PW'(1), PW'(0));
        else check("sb_beat", m_pay, sb_q.pop_front());
        out_cyc.push_back(cyc);
      end else if (m_vld) begin
        held      <= m_pay;
        hold_pend <= 1'b1;
      end
    end
  end

  task automatic clear_model();
    sb_q.delete();
    out_cyc.delete();
    mdl_idx  = 0;
    mdl_drop = 0;
  endtask

  task automatic do_reset(input int s);
    sel      = s;
    mb       = (s == 0) ? 64 : (s == 1) ? 4 : (s == 2) ? 2 : 1;
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer one beat and wait (bounded) for it to be accepted; the model
  // computes what should come out, if anything.
  task automatic send(input logic last, input bit must_rdy);
    int   n;
    logic tr;
    n        = 0;
    s_tvalid = 1'b1;
    s_tdata  = $urandom;
    s_tkeep  = KW'($urandom);
    s_tuser  = UW'($urandom);
    s_tlast  = last;
    @(negedge clk);
    if (must_rdy) check("drop_ready", PW'(s_rdy), PW'(1));
    while (!s_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) begin
      check("accept_timeout", PW'(0), PW'(1));
      return;
    end
    if (!mdl_drop) begin
      tr = (mdl_idx == mb - 1) && !last;
      sb_q.push_back({s_tdata, s_tkeep, s_tuser, last | tr, tr});
      mdl_idx = (last || tr) ? 0 : mdl_idx + 1;
      if (tr) mdl_drop = 1;
    end else if (last) begin
      mdl_drop = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n        = 0;
    s_tvalid = 1'b0;
    while ((sb_q.size() != 0 || m_vld) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_done", PW'(sb_q.size() == 0 && !m_vld), PW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: MAX_BEATS=64, reset state, 3-beat packet passes with 1-cycle latency.
    do_reset(0);
    check("rst_m_tvalid", PW'(m_vld), PW'(0));
    check("rst_s_tready", PW'(s_rdy), PW'(1));
    check("rst_trunc_count", PW'(tc), PW'(0));
    check("rst_drop_count", PW'(dc), PW'(0));
    check("rst_tlast_trunc", PW'(m_pay[1:0]), PW'(0));
    m_tready = 1'b1;
    send(1'b0, 0);
    check("latency_1cyc", PW'(m_vld), PW'(1));
    send(1'b0, 0);
    send(1'b1, 0);
    drain();
    check("t1_beats_out", PW'(out_cyc.size()), PW'(3));
    check("t1_trunc_count", PW'(tc), PW'(0));
    check("t1_drop_count", PW'(dc), PW'(0));

    // Test 2: MAX_BEATS=4, 6-beat packet truncated, tail dropped under backpressure, then 2-beat packet.
    do_reset(1);
    m_tready = 1'b1;
    repeat (4) send(1'b0, 0);
    m_tready = 1'b0;
    send(1'b0, 1);
    send(1'b1, 1);
    m_tready = 1'b1;
    send(1'b0, 0);
    send(1'b1, 0);
    drain();
    check("t2_beats_out", PW'(out_cyc.size()), PW'(6));
    check("t2_trunc_count", PW'(tc), PW'(1));
    check("t2_drop_count", PW'(dc), PW'(2));

    // Test 3: MAX_BEATS=4, exact-length packet is not truncated, next packet still passes.
    do_reset(1);
    m_tready = 1'b1;
    repeat (3) send(1'b0, 0);
    send(1'b1, 0);
    send(1'b1, 0);
    drain();
    check("t3_beats_out", PW'(out_cyc.size()), PW'(5));
    check("t3_trunc_count", PW'(tc), PW'(0));
    check("t3_drop_count", PW'(dc), PW'(0));

    // Test 4: output stalled for 5 cycles; at most 2 beats buffered, then 1 beat/cycle in order.
    do_reset(0);
    m_tready = 1'b0;
    send(1'b0, 0);
    send(1'b0, 0);
    check("t4_ready_after_2", PW'(s_rdy), PW'(0));
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_ready", PW'(s_rdy), PW'(0));
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    repeat (3) send(1'b0, 0);
    send(1'b1, 0);
    drain();
    check("t4_beats_out", PW'(out_cyc.size()), PW'(6));
    if (out_cyc.size() == 6)
      check("t4_back_to_back", PW'(out_cyc[5] - out_cyc[0]), PW'(5));

    // Test 5: MAX_BEATS=2, reset while in DROP with beats buffered.
    do_reset(2);
    m_tready = 1'b1;
    send(1'b0, 0);
    m_tready = 1'b0;
    send(1'b0, 0);
    send(1'b0, 1);
    s_tvalid = 1'b0;
    check("t5_pre_trunc_count", PW'(tc), PW'(1));
    check("t5_pre_drop_count", PW'(dc), PW'(1));
    check("t5_pre_m_tvalid", PW'(m_vld), PW'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_tvalid", PW'(m_vld), PW'(0));
    check("t5_rst_trunc_count", PW'(tc), PW'(0));
    check("t5_rst_drop_count", PW'(dc), PW'(0));
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready = 1'b1;
    send(1'b0, 0);
    send(1'b1, 0);
    drain();
    check("t5_beats_out", PW'(out_cyc.size()), PW'(2));
    check("t5_trunc_count", PW'(tc), PW'(0));

    // Test 6: MAX_BEATS=1, CNT_WIDTH=2, six 2-beat packets saturate both counters.
    do_reset(3);
    m_tready = 1'b1;
    repeat (6) begin
      send(1'b0, 0);
      send(1'b1, 1);
    end
    drain();
    check("t6_beats_out", PW'(out_cyc.size()), PW'(6));
    check("t6_trunc_sat", PW'(tc), PW'(3));
    check("t6_drop_sat", PW'(dc), PW'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
